// File: rtl/multicycle_pkg.sv
// Shared state and instruction-class codes for the multicycle sequencer.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_IF   = 4'b0000,
    ST_ID   = 4'b0001,
    ST_EX   = 4'b0010,
    ST_MEM  = 4'b0011,
    ST_WB   = 4'b0100,
    ST_EXW  = 4'b0101,
    ST_WBW  = 4'b0110,
    ST_PCUP = 4'b1000,
    ST_HALT = 4'b1001,
    ST_IDLE = 4'b1010
  } state_t;

  localparam logic [2:0] TIPO_R      = 3'd0;
  localparam logic [2:0] TIPO_IARITH = 3'd1;
  localparam logic [2:0] TIPO_LOAD   = 3'd2;
  localparam logic [2:0] TIPO_STORE  = 3'd3;
  localparam logic [2:0] TIPO_BRANCH = 3'd4;

  // Wide enough for MEM_TIMEOUT up to 255 and both wait counts.
  localparam int TIMER_W = 8;

  // Where execution goes once EX (and any EX wait) is finished.
  // Illegal classes map to HALT; the caller flags the error.
  function automatic state_t ex_target(input logic [2:0] tipo);
    case (tipo)
      TIPO_R, TIPO_IARITH:    return ST_WB;
      TIPO_LOAD, TIPO_STORE:  return ST_MEM;
      TIPO_BRANCH:            return ST_PCUP;
      default:                return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_seq_stage_timer.sv
// Loadable down-counter. done is high while the count sits at zero, so a
// stage loaded with N-1 on entry reaches done in its N-th cycle.
module stage_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load has priority over counting; count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: IF/ID/EX/MEM/WB/PCUP with optional wait
// stages after EX and WB, a bounded MEM handshake and a retired-instruction
// counter.
//
// state | meaning
// IDLE  | waiting for start
// IF    | instruction fetch strobe
// ID    | decode; zero instruction halts
// EX    | execute strobe
// EXW   | WAIT_EX extra cycles after EX
// MEM   | memory request held until mem_ack or timeout
// WB    | write-back strobe
// WBW   | WAIT_WB extra cycles after WB
// PCUP  | PC update, retires the instruction
// HALT  | stopped until reset
module multicycle_seq
  import multicycle_pkg::*;
#(
  parameter int WAIT_EX     = 1,
  parameter int WAIT_WB     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instrucao,
  input  logic [2:0]  tipo,
  input  logic        mem_ack,
  output logic [3:0]  estado,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic        halted,
  output logic        err,
  output logic [31:0] instret
);

  localparam logic [TIMER_W-1:0] EXW_LOAD = TIMER_W'(WAIT_EX - 1);
  localparam logic [TIMER_W-1:0] WBW_LOAD = TIMER_W'(WAIT_WB - 1);
  localparam logic [TIMER_W-1:0] MEM_LOAD = TIMER_W'(MEM_TIMEOUT - 1);

  state_t              state;
  state_t              next_state;
  state_t              ex_next;
  logic                set_err;
  logic                store_q;
  logic                err_q;
  logic [31:0]         instret_q;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_done;
  logic [TIMER_W-1:0]  tmr_val;

  assign ex_next = ex_target(tipo);

  stage_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; set_err marks the transitions into an abnormal halt.
  always_comb begin
    next_state = state;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_IF;
      ST_IF:   next_state = ST_ID;
      ST_ID:   next_state = (instrucao == 32'd0) ? ST_HALT : ST_EX;
      ST_EX: begin
        if (WAIT_EX > 0) begin
          next_state = ST_EXW;
        end else begin
          next_state = ex_next;
          set_err    = (ex_next == ST_HALT);
        end
      end
      ST_EXW: begin
        if (tmr_done) begin
          next_state = ex_next;
          set_err    = (ex_next == ST_HALT);
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          next_state = store_q ? ST_PCUP : ST_WB;
        end else if (tmr_done) begin
          next_state = ST_HALT;
          set_err    = 1'b1;
        end
      end
      ST_WB:   next_state = (WAIT_WB > 0) ? ST_WBW : ST_PCUP;
      ST_WBW:  if (tmr_done) next_state = ST_PCUP;
      ST_PCUP: next_state = ST_IF;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  // Timer is loaded on entry to a timed stage and counts while inside one.
  always_comb begin
    tmr_load = (next_state != state);
    tmr_val  = '0;
    case (next_state)
      ST_EXW:  tmr_val  = EXW_LOAD;
      ST_WBW:  tmr_val  = WBW_LOAD;
      ST_MEM:  tmr_val  = MEM_LOAD;
      default: tmr_load = 1'b0;
    endcase
    tmr_en = (state == ST_EXW) || (state == ST_WBW) || (state == ST_MEM);
  end

  // tipo is only valid around EX, so the load/store choice is captured on
  // the way into MEM; err and instret are plain accumulating registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q   <= 1'b0;
      err_q     <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      if (((state == ST_EX) || (state == ST_EXW)) && (next_state == ST_MEM))
        store_q <= (tipo == TIPO_STORE);
      if (set_err)
        err_q <= 1'b1;
      if (state == ST_PCUP)
        instret_q <= instret_q + 32'd1;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    estado  = state;
    if_en   = (state == ST_IF);
    id_en   = (state == ST_ID);
    ex_en   = (state == ST_EX);
    mem_req = (state == ST_MEM);
    wb_en   = (state == ST_WB);
    pc_en   = (state == ST_PCUP);
    halted  = (state == ST_HALT);
    err     = err_q;
    instret = instret_q;
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: builds each instruction's expected
// state trace from the stage rules, drives it, and compares every cycle.
module tb_multicycle_seq;

  localparam int WAIT_EX     = 1;
  localparam int WAIT_WB     = 2;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [3:0] S_IF   = 4'b0000;
  localparam logic [3:0] S_ID   = 4'b0001;
  localparam logic [3:0] S_EX   = 4'b0010;
  localparam logic [3:0] S_MEM  = 4'b0011;
  localparam logic [3:0] S_WB   = 4'b0100;
  localparam logic [3:0] S_EXW  = 4'b0101;
  localparam logic [3:0] S_WBW  = 4'b0110;
  localparam logic [3:0] S_PCUP = 4'b1000;
  localparam logic [3:0] S_HALT = 4'b1001;
  localparam logic [3:0] S_IDLE = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instrucao = 32'd0;
  logic [2:0]  tipo = 3'd0;
  logic        mem_ack = 1'b0;
  logic [3:0]  estado;
  logic        if_en, id_en, ex_en, wb_en, pc_en, mem_req, halted, err;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic [3:0]  exp_state = S_IDLE;
  logic        exp_err = 1'b0;
  logic [31:0] exp_instret = 32'd0;
  logic        pcup_pend = 1'b0;
  logic        err_pending = 1'b0;
  logic [31:0] cur_instr = 32'd0;
  logic [2:0]  cur_tipo = 3'd0;
  int          mem_cnt = 0;
  int          wb_cnt = 0;

  multicycle_seq #(
    .WAIT_EX     (WAIT_EX),
    .WAIT_WB     (WAIT_WB),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instrucao (instrucao),
    .tipo      (tipo),
    .mem_ack   (mem_ack),
    .estado    (estado),
    .if_en     (if_en),
    .id_en     (id_en),
    .ex_en     (ex_en),
    .wb_en     (wb_en),
    .pc_en     (pc_en),
    .mem_req   (mem_req),
    .halted    (halted),
    .err       (err),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("estado",  estado,  exp_state);
      chk("if_en",   if_en,   exp_state == S_IF);
      chk("id_en",   id_en,   exp_state == S_ID);
      chk("ex_en",   ex_en,   exp_state == S_EX);
      chk("mem_req", mem_req, exp_state == S_MEM);
      chk("wb_en",   wb_en,   exp_state == S_WB);
      chk("pc_en",   pc_en,   exp_state == S_PCUP);
      chk("halted",  halted,  exp_state == S_HALT);
      chk("err",     err,     exp_err);
      chk("instret", instret, exp_instret);
    end
  end

  // Strobe tallies used by the literal per-instruction checks.
  always @(negedge clk) begin
    if (mem_req) mem_cnt++;
    if (wb_en)   wb_cnt++;
  end

  // One cycle in state s: set expectations and drive inputs, with noise on
  // every input outside the window where it matters.
  task automatic drive_cycle(input logic [3:0] s, input logic ack_now, input logic st);
    @(posedge clk);
    #1;
    if (pcup_pend) exp_instret = exp_instret + 32'd1;
    pcup_pend = (s == S_PCUP);
    exp_state = s;
    exp_err   = (s == S_HALT) ? err_pending : 1'b0;
    start     = (s == S_IDLE || s == S_HALT) ? st : 1'($urandom);
    instrucao = (s == S_ID) ? cur_instr : $urandom;
    tipo      = (s == S_EX || s == S_EXW) ? cur_tipo : 3'($urandom_range(7, 0));
    mem_ack   = (s == S_MEM) ? ack_now : 1'($urandom);
  endtask

  // Expected trace of one instruction from IF, derived from the stage rules.
  // ack_at: MEM cycle (1-based) carrying mem_ack, 0 = never.
  task automatic run_instr(input logic [31:0] ins, input logic [2:0] tp,
                           input int ack_at, output int n);
    logic [3:0] sq[$];
    bit         aq[$];
    bit         halt_err;
    bit         acked;
    halt_err = 1'b0;
    acked    = 1'b0;
    sq.push_back(S_IF); aq.push_back(1'b0);
    sq.push_back(S_ID); aq.push_back(1'b0);
    if (ins == 32'd0) begin
      sq.push_back(S_HALT); aq.push_back(1'b0);
    end else begin
      sq.push_back(S_EX); aq.push_back(1'b0);
      for (int i = 0; i < WAIT_EX; i++) begin sq.push_back(S_EXW); aq.push_back(1'b0); end
      if (tp == 3'd2 || tp == 3'd3) begin
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
          if (!acked) begin
            sq.push_back(S_MEM);
            aq.push_back(k == ack_at);
            if (k == ack_at) acked = 1'b1;
          end
        end
      end
      if (tp <= 3'd1 || (tp == 3'd2 && acked)) begin
        sq.push_back(S_WB); aq.push_back(1'b0);
        for (int i = 0; i < WAIT_WB; i++) begin sq.push_back(S_WBW); aq.push_back(1'b0); end
        sq.push_back(S_PCUP); aq.push_back(1'b0);
      end else if (tp == 3'd4 || (tp == 3'd3 && acked)) begin
        sq.push_back(S_PCUP); aq.push_back(1'b0);
      end else begin
        halt_err = 1'b1;
        sq.push_back(S_HALT); aq.push_back(1'b0);
      end
    end
    cur_instr = ins;
    cur_tipo  = tp;
    mem_cnt   = 0;
    wb_cnt    = 0;
    foreach (sq[i]) begin
      if (sq[i] == S_HALT) err_pending = halt_err;
      drive_cycle(sq[i], aq[i], 1'b0);
    end
    n = sq.size();
  endtask

  // Let the last cycle's strobes be tallied, then pin them to literals.
  task automatic chk_instr(input string nm, input int n, input int exp_n,
                           input int exp_mem, input int exp_wb);
    @(negedge clk);
    #1;
    chk({nm, "_len"},   n,       exp_n);
    chk({nm, "_mem"},   mem_cnt, exp_mem);
    chk({nm, "_wb"},    wb_cnt,  exp_wb);
  endtask

  task automatic do_reset(input logic st);
    chk_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    start   = st;
    mem_ack = 1'b0;
    #1;
    chk("rst_estado",  estado,  S_IDLE);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_halted",  halted,  1'b0);
    chk("rst_err",     err,     1'b0);
    chk("rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    exp_state   = S_IDLE;
    exp_err     = 1'b0;
    exp_instret = 32'd0;
    pcup_pend   = 1'b0;
    err_pending = 1'b0;
    chk_en      = 1'b1;
  endtask

  initial begin
    int n;
    int c;
    int ni;
    logic [2:0] tp;

    // Normal mix ending in a zero-instruction halt.
    do_reset(1'b1);
    run_instr(32'h0000_1234, 3'd0, 0, n);  chk_instr("r_type", n, 8, 0, 1);
    run_instr(32'h0000_0abc, 3'd2, 1, n);  chk_instr("load",   n, 9, 1, 1);
    run_instr(32'h0000_0def, 3'd3, 1, n);  chk_instr("store",  n, 6, 1, 0);
    run_instr(32'h0000_0777, 3'd4, 0, n);  chk_instr("branch", n, 5, 0, 0);
    run_instr(32'h0000_0000, 3'd0, 0, n);  chk_instr("zero",   n, 3, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(S_HALT, 1'b0, 1'b1);
    #1;
    chk("zero_halt_estado",  estado,  S_HALT);
    chk("zero_halt_err",     err,     1'b0);
    chk("zero_halt_instret", instret, 32'd4);

    // MEM timeout.
    do_reset(1'b1);
    run_instr(32'h0000_0101, 3'd2, 0, n);  chk_instr("timeout", n, 21, 16, 0);
    drive_cycle(S_HALT, 1'b0, 1'b1);
    #1;
    chk("timeout_err",     err,     1'b1);
    chk("timeout_instret", instret, 32'd0);

    // Ack in the last allowed cycle, then an illegal class.
    do_reset(1'b1);
    run_instr(32'h0000_0202, 3'd2, MEM_TIMEOUT, n);  chk_instr("late_ack", n, 24, 16, 1);
    run_instr(32'h0000_0303, 3'd4, 0, n);
    run_instr(32'h0000_0404, 3'd6, 0, n);  chk_instr("illegal", n, 5, 0, 0);
    drive_cycle(S_HALT, 1'b0, 1'b0);
    #1;
    chk("illegal_err",     err,     1'b1);
    chk("illegal_instret", instret, 32'd2);

    // Asynchronous reset in the middle of MEM.
    do_reset(1'b1);
    run_instr(32'h0000_0505, 3'd1, 0, n);
    cur_instr = 32'h0000_0606;
    cur_tipo  = 3'd2;
    drive_cycle(S_IF, 1'b0, 1'b0);
    drive_cycle(S_ID, 1'b0, 1'b0);
    drive_cycle(S_EX, 1'b0, 1'b0);
    drive_cycle(S_EXW, 1'b0, 1'b0);
    drive_cycle(S_MEM, 1'b0, 1'b0);
    drive_cycle(S_MEM, 1'b0, 1'b0);
    chk("pre_rst_instret", instret, 32'd1);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_estado",  estado,  S_IDLE);
    chk("async_mem_req", mem_req, 1'b0);
    chk("async_instret", instret, 32'd0);

    // instret wrap.
    do_reset(1'b0);
    drive_cycle(S_IDLE, 1'b0, 1'b0);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    drive_cycle(S_IDLE, 1'b0, 1'b1);
    run_instr(32'h0000_0707, 3'd0, 0, n);
    run_instr(32'h0000_0808, 3'd1, 0, n);
    drive_cycle(S_IF, 1'b0, 1'b0);
    #1;
    chk("wrap_instret", instret, 32'd1);

    // Randomized episodes, each ending in one of the halt causes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset(1'b0);
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) drive_cycle(S_IDLE, 1'b0, 1'b0);
      drive_cycle(S_IDLE, 1'b0, 1'b1);
      ni = $urandom_range(6, 2);
      for (int i = 0; i < ni; i++) begin
        tp = 3'($urandom_range(4, 0));
        run_instr($urandom | 32'd1, tp, $urandom_range(MEM_TIMEOUT, 1), n);
      end
      c = $urandom_range(2, 0);
      if (c == 0)      run_instr(32'd0, 3'($urandom_range(7, 0)), 1, n);
      else if (c == 1) run_instr($urandom | 32'd1, 3'($urandom_range(7, 5)), 1, n);
      else             run_instr($urandom | 32'd1, 3'($urandom_range(3, 2)), 0, n);
      for (int i = 0; i < 3; i++) drive_cycle(S_HALT, 1'b0, 1'($urandom));
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 Parameter WAIT_EX, default 1: wait cycles inserted after EX (0..15).
REQ-002 Parameter WAIT_WB, default 2: wait cycles inserted after WB (0..15).
REQ-003 Parameter MEM_TIMEOUT, default 16: maximum MEM cycles without mem_ack (1..255).
REQ-004 The clock port SHALL be clk (input, 1): the single clock; all state changes on posedge.
REQ-005 The reset port SHALL be rst_n (input, 1): asynchronous, active-low reset.
REQ-006 start, input, 1: leaves IDLE when high in IDLE.
REQ-007 instrucao, input, 32: fetched instruction, valid while in ID.
REQ-008 tipo, input, 3: decoded class, valid while in EX/EXW.
REQ-009 mem_ack, input, 1: data memory completion.
REQ-010 estado, output, 4: current state code.
REQ-011 if_en, id_en, ex_en, wb_en, pc_en, outputs, 1 each: stage strobes.
REQ-012 mem_req, output, 1: memory access request.
REQ-013 halted, output, 1: sequencer stopped.
REQ-014 err, output, 1: abnormal halt.
REQ-015 instret, output, 32: retired-instruction count.

Function
REQ-016 The block SHALL use these state codes: IF=0000, ID=0001, EX=0010, MEM=0011, WB=0100, EXW=0101, WBW=0110, PCUP=1000, HALT=1001, IDLE=1010; estado SHALL equal the state register.
REQ-017 The block SHALL use these tipo codes: R=0, IARITH=1, LOAD=2, STORE=3, BRANCH=4; codes 5-7 are illegal.
REQ-018 Transitions: IDLE->IF when start=1. IF->ID after 1 cycle. ID->HALT if instrucao==0, otherwise ID->EX.
REQ-019 EX->EXW when WAIT_EX>0; EXW SHALL persist exactly WAIT_EX cycles.
REQ-020 On leaving EX/EXW: LOAD/STORE->MEM; R/IARITH->WB; BRANCH->PCUP; illegal tipo->HALT with err=1.
REQ-021 MEM SHALL hold mem_req=1 every cycle; mem_ack=1 in any MEM cycle exits that cycle (LOAD->WB, STORE->PCUP).
REQ-022 After MEM_TIMEOUT MEM cycles without ack the block SHALL go to HALT with err=1; ack in the final cycle wins over timeout.
REQ-023 WB->WBW when WAIT_WB>0, WBW SHALL last WAIT_WB cycles, then go to PCUP; WB->PCUP directly when WAIT_WB=0.
REQ-024 PCUP SHALL last 1 cycle, increment instret (wrap 2^32-1->0), then go to IF.
REQ-025 HALT SHALL be sticky until reset; start is ignored there; halted=1 only in HALT.
REQ-026 Outputs SHALL be Moore, decoded from state: if_en=IF, id_en=ID, ex_en=EX, mem_req=MEM, wb_en=WB, pc_en=PCUP.
REQ-027 start outside IDLE and mem_ack outside MEM SHALL be ignored.
REQ-028 err SHALL be sticky until reset.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, all strobes/halted/err=0, instret=0, and wait/timeout counters=0, including mid-MEM (mem_req drops asynchronously).
REQ-030 The first transition SHALL occur on the first posedge clk after rst_n deasserts.

Structure
REQ-031 State codes and tipo codes SHALL live in shared package multicycle_pkg.
REQ-032 One sub-module, stage_timer (loadable down-counter with done flag), SHALL serve EXW, WBW and the MEM timeout.

Verification
REQ-033 R-type (tipo=0, instrucao nonzero), defaults: start -> states IF,ID,EX,EXW,WB,WBW,WBW,PCUP (8 cycles), instret=1.
REQ-034 LOAD with mem_ack in the 1st MEM cycle: 9 cycles, wb_en pulses once, mem_req high exactly 1 cycle; STORE: 6 cycles, no wb_en; BRANCH: 5 cycles, no mem_req/wb_en.
REQ-035 instrucao=0 in ID -> HALT next cycle, halted=1, err=0, instret unchanged; later start pulses leave estado=1001.
REQ-036 LOAD with mem_ack never asserted, MEM_TIMEOUT=16 -> mem_req high 16 cycles, then HALT with err=1; repeat with ack in the 16th cycle -> WB, err=0.
REQ-037 rst_n pulsed low during MEM -> estado=1010 and mem_req=0 immediately without clk; instret=0.
REQ-038 instret preset near 32'hFFFFFFFF via force, two R-type retirements -> instret=0 then 1.
